// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element operand feeder.
//   DEFAULT_WIDTH : default operand / result width
//   DEFAULT_DEPTH : default number of operand-pair buffer entries
//   pe_state_e    : feeder FSM state encoding
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // IDLE   : loading pairs, pe holds its value
    // CLEAR  : one-cycle clear pulse to the pe accumulator
    // STREAM : one stored pair per cycle into the pe
    // SETTLE : pe holds the final sum, which is captured into result
    // DONE   : one-cycle done pulse, buffer released for the next run
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } pe_state_e;

endpackage

// File: rtl/pe_operand_buf.sv
// ---------------------------------------------------------------------------
// pe_operand_buf
// DEPTH x 2*WIDTH register file holding operand pairs {a, b}.
// Ports:
//   clk_i          clock
//   we_i           write enable for one pair
//   waddr_i        write index
//   wdata_a_i/b_i  operand pair being written
//   raddr_i        combinational read index (stream counter)
//   rdata_a_o/b_o  operand pair at raddr_i
// Storage is deliberately not reset: the feeder's pair count gates every read.
// ---------------------------------------------------------------------------
module pe_operand_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_a_i,
    input  logic [WIDTH-1:0]         wdata_b_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_a_o,
    output logic [WIDTH-1:0]         rdata_b_o
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] rdata;

    // Single write port; a pair is stored as {a, b} in one entry.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wdata_a_i, wdata_b_i};
        end
    end

    // Asynchronous read so the operand reaches the pe in the same cycle the
    // stream index selects it.
    assign rdata     = mem_q[raddr_i];
    assign rdata_a_o = rdata[2*WIDTH-1:WIDTH];
    assign rdata_b_o = rdata[WIDTH-1:0];

endmodule

// File: rtl/pe_feeder.sv
// ---------------------------------------------------------------------------
// pe_feeder
// Buffers operand pairs and streams them into an external multiply-accumulate
// pe, then captures the pe accumulator as the dot product.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/wr_a/wr_b load one operand pair (IDLE only, ignored when full)
//   start           begin a run over the loaded pairs (IDLE only)
//   pe_rst          clear pulse to the pe accumulator
//   pe_a/pe_b       operands driven to the pe
//   pe_c            pe accumulator value
//   result          captured dot product
//   done            one-cycle pulse, result valid
//   busy            FSM not in IDLE
//   count/full      pairs loaded / buffer full
// ---------------------------------------------------------------------------
module pe_feeder
    import pe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_a,
    input  logic [WIDTH-1:0]       wr_b,
    input  logic                   start,
    output logic                   pe_rst,
    output logic [WIDTH-1:0]       pe_a,
    output logic [WIDTH-1:0]       pe_b,
    input  logic [WIDTH-1:0]       pe_c,
    output logic [WIDTH-1:0]       result,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    pe_state_e         state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     streamIdx_q, streamIdx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              bufWe;
    logic              isFull;
    logic [WIDTH-1:0]  bufA, bufB;

    assign isFull = (count_q == CW'(DEPTH));

    pe_operand_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_buf (
        .clk_i    (clk),
        .we_i     (bufWe),
        .waddr_i  (count_q[IW-1:0]),
        .wdata_a_i(wr_a),
        .wdata_b_i(wr_b),
        .raddr_i  (streamIdx_q[IW-1:0]),
        .rdata_a_o(bufA),
        .rdata_b_o(bufB)
    );

    // Next-state logic. Writes and start are only honoured in IDLE; a write
    // in the same cycle as start still lands, so the run includes it because
    // CLEAR reads the already-incremented count.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        streamIdx_d = streamIdx_q;
        result_d    = result_q;
        bufWe       = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_en && !isFull) begin
                    bufWe   = 1'b1;
                    count_d = count_q + CW'(1);
                end
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                streamIdx_d = '0;
                state_d     = (count_q != '0) ? STREAM : SETTLE;
            end
            STREAM: begin
                if (streamIdx_q == count_q - CW'(1)) begin
                    state_d = SETTLE;
                end else begin
                    streamIdx_d = streamIdx_q + CW'(1);
                end
            end
            SETTLE: begin
                // The pe registered the last product on the previous edge and
                // holds it now that the operands are zero.
                result_d = pe_c;
                state_d  = DONE;
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset. The buffer itself is not
    // cleared; zeroing count makes its old contents unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            streamIdx_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            streamIdx_q <= streamIdx_d;
            result_q    <= result_d;
        end
    end

    // Outputs are decoded from registered state only; operands are zero
    // outside STREAM so the pe accumulator holds.
    assign pe_rst = (state_q == CLEAR);
    assign pe_a   = (state_q == STREAM) ? bufA : '0;
    assign pe_b   = (state_q == STREAM) ? bufB : '0;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign result = result_q;
    assign count  = count_q;
    assign full   = isFull;

endmodule

// File: tb/tb_pe_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_feeder
// Drives pe_feeder connected to a behavioural multiply-accumulate pe and
// compares against a pair-list reference model (sum of a*b mod 2^WIDTH,
// done in cycle n+3 after start).
// ---------------------------------------------------------------------------
module tb_pe_feeder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_en;
    logic [WIDTH-1:0]       wr_a;
    logic [WIDTH-1:0]       wr_b;
    logic                   start;
    logic                   pe_rst;
    logic [WIDTH-1:0]       pe_a;
    logic [WIDTH-1:0]       pe_b;
    logic [WIDTH-1:0]       pe_c = '0;
    logic [WIDTH-1:0]       result;
    logic                   done;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;
    logic                   full;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] modelA [$];
    logic [WIDTH-1:0] modelB [$];

    pe_feeder #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .wr_a  (wr_a),
        .wr_b  (wr_b),
        .start (start),
        .pe_rst(pe_rst),
        .pe_a  (pe_a),
        .pe_b  (pe_b),
        .pe_c  (pe_c),
        .result(result),
        .done  (done),
        .busy  (busy),
        .count (count),
        .full  (full)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Behavioural pe: registered multiply-accumulate, cleared only by pe_rst
    // so a stale sum survives a feeder reset unless CLEAR does its job.
    always @(posedge clk) begin
        if (pe_rst) begin
            pe_c <= '0;
        end else begin
            pe_c <= pe_c + pe_a * pe_b;
        end
    end

    // Immediate-assertion comparison point.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, return on the next one.
    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic st);
        wr_en = we;
        wr_a  = a;
        wr_b  = b;
        start = st;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    // Load one pair while idle; the model keeps at most DEPTH pairs.
    task automatic loadPair(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        if (modelA.size() < DEPTH) begin
            modelA.push_back(a);
            modelB.push_back(b);
        end
        applyStimulus(1'b1, a, b, 1'b0);
        checkOutput({tag, "_count"}, 64'(count), 64'(modelA.size()));
        checkOutput({tag, "_idle_pe_a"}, 64'(pe_a), 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] modelDot();
        logic [WIDTH-1:0] s = '0;
        for (int i = 0; i < modelA.size(); i++) begin
            s += modelA[i] * modelB[i];
        end
        return s;
    endfunction

    // Full run: optional same-cycle write with start, a write and start
    // during busy that must both be ignored, then done latency and result.
    task automatic runCheck(input string tag, input logic we,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int               n;
        int               cyc;
        logic [WIDTH-1:0] expResult;
        if (we && modelA.size() < DEPTH) begin
            modelA.push_back(a);
            modelB.push_back(b);
        end
        n         = modelA.size();
        expResult = modelDot();
        applyStimulus(we, a, b, 1'b1);
        cyc = 1;
        checkOutput({tag, "_pe_rst_c1"}, 64'(pe_rst), 64'd1);
        checkOutput({tag, "_busy_c1"}, 64'(busy), 64'd1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        cyc = 2;
        checkOutput({tag, "_count_busy_wr"}, 64'(count), 64'(n));
        checkOutput({tag, "_pe_rst_c2"}, 64'(pe_rst), 64'd0);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_done_cycle"}, 64'(cyc), 64'(n + 3));
        checkOutput({tag, "_result"}, 64'(result), 64'(expResult));
        @(negedge clk);
        checkOutput({tag, "_count_after"}, 64'(count), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_result_hold"}, 64'(result), 64'(expResult));
        modelA.delete();
        modelB.delete();
    endtask

    // Directed scenarios followed by randomized runs.
    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        wr_a  = '0;
        wr_b  = '0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_full", 64'(full), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_pe_rst", 64'(pe_rst), 64'd0);
        checkOutput("reset_pe_b", 64'(pe_b), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);

        // Three small pairs: 1+4+9 = 14, done six cycles after start.
        loadPair("t1_ld0", 32'd1, 32'd1);
        loadPair("t1_ld1", 32'd2, 32'd2);
        loadPair("t1_ld2", 32'd3, 32'd3);
        runCheck("t1", 1'b0, '0, '0);

        // Fill the buffer with (2,3), then one write past full.
        for (int i = 0; i < DEPTH; i++) begin
            loadPair("t2_ld", 32'd2, 32'd3);
        end
        checkOutput("t2_full", 64'(full), 64'd1);
        loadPair("t2_extra", 32'd9, 32'd9);
        checkOutput("t2_full_after_extra", 64'(full), 64'd1);
        runCheck("t2", 1'b0, '0, '0);
        checkOutput("t2_full_cleared", 64'(full), 64'd0);

        // Empty run.
        runCheck("t3_empty", 1'b0, '0, '0);

        // Back-to-back runs: the second must not inherit the first sum.
        loadPair("t4_ld", 32'd5, 32'd5);
        runCheck("t4a", 1'b0, '0, '0);
        loadPair("t4_ld", 32'd1, 32'd7);
        runCheck("t4b", 1'b0, '0, '0);

        // Reset in the middle of streaming a four-pair run.
        for (int i = 0; i < 4; i++) begin
            loadPair("t5_ld", 32'd3, 32'd4);
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_streaming", 64'(pe_a), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_count", 64'(count), 64'd0);
        checkOutput("t5_rst_result", 64'(result), 64'd0);
        checkOutput("t5_rst_pe_rst", 64'(pe_rst), 64'd0);
        checkOutput("t5_rst_pe_a", 64'(pe_a), 64'd0);
        checkOutput("t5_rst_done", 64'(done), 64'd0);
        modelA.delete();
        modelB.delete();
        loadPair("t5_ld2", 32'd4, 32'd4);
        runCheck("t5_rerun", 1'b0, '0, '0);

        // Write in the same cycle as start is part of the run: 4 + 9 = 13.
        loadPair("t6_ld", 32'd2, 32'd2);
        runCheck("t6", 1'b1, 32'd3, 32'd3);

        // Random runs with full-width operands (sums wrap modulo 2^WIDTH).
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                loadPair("rnd_ld", WIDTH'($urandom), WIDTH'($urandom));
            end
            runCheck("rnd", 1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
